// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: credit-controlled prefetch queue in front of the BRAM program port.
// Optional statistics counters are enabled by defining FETCH_PREFETCH_STATS_EN.
module fetch_prefetch_queue #(
    parameter int                    PC_WIDTH = 16,
    parameter int                    DEPTH    = 4,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
    input  logic                     sysclk,
    input  logic                     rst,
    output logic                     imem_en,
    output logic [PC_WIDTH-3:0]      imem_addr,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect_valid,
    input  logic [PC_WIDTH-1:0]      redirect_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [31:0]              instr_out,
    output logic [PC_WIDTH-1:0]      pc_out,
    output logic [PC_WIDTH-1:0]      pc_plus4_out
`ifdef FETCH_PREFETCH_STATS_EN
    ,
    output logic [31:0]              stat_redirects,
    output logic [31:0]              stat_bubbles
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]       DEPTH_C = CW'(DEPTH);
    localparam logic [31:0]         NOP     = 32'h0000_0013;
    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

    logic [31:0]          r_q_instr [DEPTH];
    logic [PC_WIDTH-1:0]  r_q_pc    [DEPTH];
    logic [AW-1:0]        r_rd_ptr;
    logic [AW-1:0]        r_wr_ptr;
    logic [CW-1:0]        r_occ;
    logic                 r_inflight;
    logic [PC_WIDTH-1:0]  r_inflight_pc;
    logic [PC_WIDTH-1:0]  r_fetch_pc;

    logic                 w_head_valid;
    logic                 w_pop;
    logic                 w_push;
    logic [CW-1:0]        w_count;
    logic                 w_credit;
    logic [PC_WIDTH-1:0]  w_redir_pc;

    // Handshake: the head is consumed when instr_valid && instr_ready in a cycle
    // without redirect_valid; a redirect voids any pop in that same cycle.
    assign w_head_valid = (r_occ != '0);
    assign w_pop        = w_head_valid && instr_ready && !redirect_valid;
    assign w_push       = r_inflight && !redirect_valid;
    assign w_count      = r_occ + CW'(r_inflight);
    assign w_credit     = (w_count - CW'(w_pop)) < DEPTH_C;
    assign w_redir_pc   = redirect_pc & ~PC_WIDTH'(3);

    assign imem_en   = rst && (redirect_valid || w_credit);
    assign imem_addr = redirect_valid ? w_redir_pc[PC_WIDTH-1:2] : r_fetch_pc[PC_WIDTH-1:2];

    assign instr_valid  = w_head_valid;
    assign instr_out    = w_head_valid ? r_q_instr[r_rd_ptr] : NOP;
    assign pc_out       = w_head_valid ? r_q_pc[r_rd_ptr] : '0;
    assign pc_plus4_out = w_head_valid ? (r_q_pc[r_rd_ptr] + PC_STEP) : '0;

    always_ff @(posedge sysclk) begin
        if (!rst) begin
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_occ         <= '0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_fetch_pc    <= RESET_PC;
        end else if (redirect_valid) begin
            // The redirect read is issued this cycle, so it is the only thing in flight afterwards.
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_occ         <= '0;
            r_inflight    <= 1'b1;
            r_inflight_pc <= w_redir_pc;
            r_fetch_pc    <= w_redir_pc + PC_STEP;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_occ      <= r_occ + CW'(w_push) - CW'(w_pop);
            r_inflight <= imem_en;
            if (imem_en) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + PC_STEP;
            end
        end
    end

    // Credit accounting guarantees the tail slot is free and never the head being popped.
    always_ff @(posedge sysclk) begin
        if (rst && w_push) begin
            r_q_instr[r_wr_ptr] <= imem_rdata;
            r_q_pc[r_wr_ptr]    <= r_inflight_pc;
        end
    end

`ifdef FETCH_PREFETCH_STATS_EN
    logic [31:0] r_stat_redirects;
    logic [31:0] r_stat_bubbles;

    always_ff @(posedge sysclk) begin
        if (!rst) begin
            r_stat_redirects <= '0;
            r_stat_bubbles   <= '0;
        end else begin
            if (redirect_valid) begin
                r_stat_redirects <= r_stat_redirects + 32'd1;
            end
            if (!w_head_valid) begin
                r_stat_bubbles <= r_stat_bubbles + 32'd1;
            end
        end
    end

    assign stat_redirects = r_stat_redirects;
    assign stat_bubbles   = r_stat_bubbles;
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: directed table, corner sequences, random run vs a queue model.
module tb_fetch_prefetch_queue;
    localparam int             PW       = 16;
    localparam int             DEPTH    = 4;
    localparam logic [PW-1:0]  RESET_PC = 16'h0000;
    localparam logic [31:0]    NOP      = 32'h0000_0013;

    logic           sysclk = 1'b0;
    logic           rst = 1'b0;
    logic           imem_en;
    logic [PW-3:0]  imem_addr;
    logic [31:0]    imem_rdata = 32'h0;
    logic           redirect_valid = 1'b0;
    logic [PW-1:0]  redirect_pc = '0;
    logic           instr_valid;
    logic           instr_ready = 1'b0;
    logic [31:0]    instr_out;
    logic [PW-1:0]  pc_out;
    logic [PW-1:0]  pc_plus4_out;
`ifdef FETCH_PREFETCH_STATS_EN
    logic [31:0]    stat_redirects;
    logic [31:0]    stat_bubbles;
`endif

    fetch_prefetch_queue #(.PC_WIDTH(PW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .sysclk(sysclk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
        .pc_out(pc_out), .pc_plus4_out(pc_plus4_out)
`ifdef FETCH_PREFETCH_STATS_EN
        , .stat_redirects(stat_redirects), .stat_bubbles(stat_bubbles)
`endif
    );

    // Clock / program memory (word n holds n; garbage when not enabled)
    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) begin
        imem_rdata <= imem_en ? {18'h0, imem_addr} : 32'hDEAD_BEEF;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of PCs awaiting decode plus the one outstanding read.
    logic [PW-1:0]  exp_q[$];
    logic           m_known = 1'b0;
    logic           m_inf = 1'b0;
    logic [PW-1:0]  m_inf_pc = '0;
    logic [PW-1:0]  m_fetch = '0;
    logic [31:0]    m_redirs = 0;
    logic [31:0]    m_bub = 0;

    function automatic logic [31:0] word_at(input logic [PW-1:0] pc);
        return {18'h0, pc[PW-1:2]};
    endfunction

    task automatic step(input logic r, input logic rv, input logic [PW-1:0] rpc, input logic rdy);
        logic          e_valid, e_pop, e_en;
        logic [PW-1:0] e_pc, e_addr_pc, tgt;
        int            occ;
        @(negedge sysclk);
        rst = r; redirect_valid = rv; redirect_pc = rpc; instr_ready = rdy;
        #1;
        occ     = exp_q.size();
        e_valid = (occ > 0);
        e_pc    = e_valid ? exp_q[0] : '0;
        e_pop   = e_valid && rdy && !rv;
        e_en    = r && (rv || ((occ + int'(m_inf) - int'(e_pop)) < DEPTH));
        tgt     = {rpc[PW-1:2], 2'b00};
        e_addr_pc = rv ? tgt : m_fetch;
        chk("imem_en", {31'h0, imem_en}, {31'h0, e_en});
        if (m_known) begin
            chk("instr_valid", {31'h0, instr_valid}, {31'h0, e_valid});
            chk("instr_out", instr_out, e_valid ? word_at(e_pc) : NOP);
            chk("pc_out", {16'h0, pc_out}, {16'h0, e_pc});
            chk("pc_plus4_out", {16'h0, pc_plus4_out}, e_valid ? {16'h0, e_pc + 16'd4} : 32'h0);
            if (e_en) chk("imem_addr", {18'h0, imem_addr}, {18'h0, e_addr_pc[PW-1:2]});
`ifdef FETCH_PREFETCH_STATS_EN
            chk("stat_redirects", stat_redirects, m_redirs);
            chk("stat_bubbles", stat_bubbles, m_bub);
`endif
        end
        if (!r) begin
            exp_q.delete(); m_inf = 1'b0; m_fetch = RESET_PC;
            m_redirs = 0; m_bub = 0; m_known = 1'b1;
        end else begin
            if (rv) m_redirs++;
            if (!e_valid) m_bub++;
            if (rv) begin
                exp_q.delete(); m_inf = 1'b1; m_inf_pc = tgt; m_fetch = tgt + 16'd4;
            end else begin
                if (e_pop) void'(exp_q.pop_front());
                if (m_inf) exp_q.push_back(m_inf_pc);
                m_inf = e_en;
                if (e_en) begin
                    m_inf_pc = m_fetch;
                    m_fetch  = m_fetch + 16'd4;
                end
            end
        end
    endtask

    typedef struct {
        logic          rst;
        logic          en;
        logic [13:0]   addr;
        logic          valid;
        logic [15:0]   pc;
        logic [31:0]   instr;
        logic [15:0]   p4;
    } vec_t;

    vec_t tbl[6];
    int   n_reads;

    initial begin
        tbl[0] = '{rst:1'b0, en:1'b0, addr:14'h0, valid:1'b0, pc:16'h0, instr:NOP,   p4:16'h0};
        tbl[1] = '{rst:1'b1, en:1'b1, addr:14'h0, valid:1'b0, pc:16'h0, instr:NOP,   p4:16'h0};
        tbl[2] = '{rst:1'b1, en:1'b1, addr:14'h1, valid:1'b0, pc:16'h0, instr:NOP,   p4:16'h0};
        tbl[3] = '{rst:1'b1, en:1'b1, addr:14'h2, valid:1'b1, pc:16'h0, instr:32'h0, p4:16'h4};
        tbl[4] = '{rst:1'b1, en:1'b1, addr:14'h3, valid:1'b1, pc:16'h4, instr:32'h1, p4:16'h8};
        tbl[5] = '{rst:1'b1, en:1'b1, addr:14'h4, valid:1'b1, pc:16'h8, instr:32'h2, p4:16'hC};

        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Reset release and startup stream
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].rst, 1'b0, '0, 1'b1);
            chk($sformatf("tbl%0d_en", i), {31'h0, imem_en}, {31'h0, tbl[i].en});
            if (tbl[i].en) chk($sformatf("tbl%0d_addr", i), {18'h0, imem_addr}, {18'h0, tbl[i].addr});
            chk($sformatf("tbl%0d_valid", i), {31'h0, instr_valid}, {31'h0, tbl[i].valid});
            chk($sformatf("tbl%0d_pc", i), {16'h0, pc_out}, {16'h0, tbl[i].pc});
            chk($sformatf("tbl%0d_instr", i), instr_out, tbl[i].instr);
            chk($sformatf("tbl%0d_p4", i), {16'h0, pc_plus4_out}, {16'h0, tbl[i].p4});
        end

        // Decode stalled for 10 cycles: exactly DEPTH reads, head held
        step(1'b0, 1'b0, '0, 1'b0);
        n_reads = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            if (imem_en) n_reads++;
            chk("stall_head_pc", {16'h0, pc_out}, 32'h0);
        end
        chk("stall_reads", n_reads, 4);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, '0, 1'b1);
            chk("drain_valid", {31'h0, instr_valid}, 32'h1);
            chk("drain_pc", {16'h0, pc_out}, 32'(4 * k));
            if (k == 0) chk("resume_issue", {31'h0, imem_en}, 32'h1);
        end

        // Redirect with 3 queued and 1 in flight, then redirect colliding with a pop
        step(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 16'h0100, 1'b0);
        chk("redir_en", {31'h0, imem_en}, 32'h1);
        chk("redir_addr", {18'h0, imem_addr}, 32'h40);
        step(1'b1, 1'b0, '0, 1'b1);
        chk("redir_bubble", {31'h0, instr_valid}, 32'h0);
        step(1'b1, 1'b1, 16'h0102, 1'b1);
        chk("redir_head_pc", {16'h0, pc_out}, 32'h0100);
        chk("redir_head_instr", instr_out, 32'h40);
        chk("redir2_addr", {18'h0, imem_addr}, 32'h40);
        step(1'b1, 1'b0, '0, 1'b1);
        chk("redir2_bubble", {31'h0, instr_valid}, 32'h0);
        step(1'b1, 1'b0, '0, 1'b1);
        chk("redir2_head_pc", {16'h0, pc_out}, 32'h0100);
        step(1'b1, 1'b0, '0, 1'b1);
        chk("redir2_next_pc", {16'h0, pc_out}, 32'h0104);
        chk("redir2_next_instr", instr_out, 32'h41);

        // PC wrap at 2^PC_WIDTH
        step(1'b1, 1'b1, 16'hFFFC, 1'b1);
        chk("wrap_addr", {18'h0, imem_addr}, 32'h3FFF);
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        chk("wrap_pc0", {16'h0, pc_out}, 32'hFFFC);
        chk("wrap_p40", {16'h0, pc_plus4_out}, 32'h0);
        step(1'b1, 1'b0, '0, 1'b1);
        chk("wrap_pc1", {16'h0, pc_out}, 32'h0);
        chk("wrap_p41", {16'h0, pc_plus4_out}, 32'h4);

        // One-cycle reset mid-stream
        step(1'b0, 1'b0, '0, 1'b1);
        chk("mrst_en", {31'h0, imem_en}, 32'h0);
        step(1'b1, 1'b0, '0, 1'b1);
        chk("mrst_empty", {31'h0, instr_valid}, 32'h0);
        chk("mrst_addr", {18'h0, imem_addr}, {18'h0, RESET_PC[PW-1:2]});
`ifdef FETCH_PREFETCH_STATS_EN
        chk("mrst_stat_redir", stat_redirects, 32'h0);
        chk("mrst_stat_bub", stat_bubbles, 32'h0);
        step(1'b1, 1'b1, 16'h0200, 1'b1);
        step(1'b1, 1'b1, 16'h0300, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        chk("stat_redir_count", stat_redirects, 32'h2);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
`endif
        step(1'b1, 1'b0, '0, 1'b1);
        chk("mrst_still_empty", {31'h0, instr_valid}, 32'h0);
        step(1'b1, 1'b0, '0, 1'b1);
        chk("mrst_head_pc", {16'h0, pc_out}, {16'h0, RESET_PC});

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 7) == 0),
                 PW'($urandom_range(0, 65535)),
                 ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
